// File: rtl/cache_types_package.sv
// ============================================================================
// Module : cache_types_package
// Brief  : Shared types for the cache SRAM: status enum and set frame layout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_types_package;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2
    } sramstate_t;

    localparam int TAG_W = 26;
    localparam int WORDS = 2;
    localparam int WAYS  = 2;

    typedef struct packed {
        logic                  v;
        logic                  dirty;
        logic [TAG_W-1:0]      tag;
        logic [WORDS-1:0][31:0] data;
    } dcache_way_t;

    // One frame carries every way of a set plus the set's replacement bit.
    typedef struct packed {
        dcache_way_t [WAYS-1:0] way;
        logic                   lru;
    } dcache_frame;

    localparam int FRAME_W = $bits(dcache_frame);

endpackage

`default_nettype wire

// File: rtl/sram_lat_timer.sv
// ============================================================================
// Module : sram_lat_timer
// Brief  : Load/count latency counter; done flags the last BUSY cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_lat_timer #(
    parameter  int LAT   = 2,
    localparam int CNT_W = $clog2(LAT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] c_DONE_CNT = CNT_W'(LAT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Loading to 1 makes the count equal the BUSY cycle number.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (count_i && !done_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == c_DONE_CNT);

endmodule

`default_nettype wire

// File: rtl/cache_sram.sv
// ============================================================================
// Module : cache_sram
// Brief  : Per-set frame storage with fixed multi-cycle FREE/BUSY/ACCESS timing.
//          Optional access counters enabled by macro CACHE_SRAM_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_sram
    import cache_types_package::*;
#(
    parameter  int SETS  = 8,
    parameter  int LAT   = 2,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               sramREN,
    input  logic               sramWEN,
    input  logic [IDX_W-1:0]   sramaddr,
    input  logic [FRAME_W-1:0] sramstore,
    output logic [FRAME_W-1:0] cacheline,
    output sramstate_t         sramstate,
    output logic [15:0]        rd_cnt,
    output logic [15:0]        wr_cnt
);

    sramstate_t         state_q, state_d;
    logic               op_wr_q, op_wr_d;
    logic [IDX_W-1:0]   addr_q,  addr_d;
    logic [FRAME_W-1:0] store_q, store_d;
    logic [FRAME_W-1:0] line_q;
    logic [FRAME_W-1:0] mem_q [SETS];

    logic w_req;
    logic w_take;
    logic w_tmr_done;
    logic w_enter_access;
    logic w_addr_ok;

    assign w_req  = sramREN | sramWEN;
    assign w_take = (state_q == FREE) && w_req;

    sram_lat_timer #(
        .LAT (LAT)
    ) u_lat_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (w_take),
        .count_i (state_q == BUSY),
        .done_o  (w_tmr_done)
    );

    // In FREE the _d operation fields carry the live request, so a LAT of 1
    // commits the request in the same edge that latches it.
    always_comb begin
        state_d        = state_q;
        op_wr_d        = op_wr_q;
        addr_d         = addr_q;
        store_d        = store_q;
        w_enter_access = 1'b0;
        case (state_q)
            FREE: begin
                if (w_req) begin
                    op_wr_d = sramWEN;
                    addr_d  = sramaddr;
                    store_d = sramstore;
                    if (LAT == 1) begin
                        state_d        = ACCESS;
                        w_enter_access = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (w_tmr_done) begin
                    state_d        = ACCESS;
                    w_enter_access = 1'b1;
                end
            end
            ACCESS:  state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FREE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            store_q <= store_d;
        end
    end

    assign w_addr_ok = ({1'b0, addr_d} < (IDX_W + 1)'(SETS));

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SETS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_enter_access && op_wr_d && w_addr_ok) begin
            mem_q[addr_d] <= store_d;
        end
    end

    // Out-of-range reads return an all-zero frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            line_q <= '0;
        end else if (w_enter_access) begin
            if (op_wr_d) begin
                line_q <= store_d;
            end else if (w_addr_ok) begin
                line_q <= mem_q[addr_d];
            end else begin
                line_q <= '0;
            end
        end
    end

    assign cacheline = line_q;
    assign sramstate = state_q;

`ifdef CACHE_SRAM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            if (op_wr_q) begin
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                end
            end else begin
                if (rd_cnt_q != 16'hFFFF) begin
                    rd_cnt_q <= rd_cnt_q + 16'd1;
                end
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_sram.sv
// ============================================================================
// Module : tb_cache_sram
// Brief  : Randomized self-checking bench for cache_sram (two configurations).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_sram;
    import cache_types_package::*;

    localparam int SETS_A = 8;
    localparam int LAT_A  = 2;
    localparam int SETS_B = 6;
    localparam int LAT_B  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ren_a, wen_a, ren_b, wen_b;
    logic [2:0] addr_a, addr_b;
    logic [FRAME_W-1:0] store_a, store_b, line_a, line_b;
    sramstate_t st_a, st_b;
    logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;

    cache_sram #(.SETS(SETS_A), .LAT(LAT_A)) u_dut_a (
        .CLK(clk), .RST(rst), .sramREN(ren_a), .sramWEN(wen_a),
        .sramaddr(addr_a), .sramstore(store_a), .cacheline(line_a),
        .sramstate(st_a), .rd_cnt(rdc_a), .wr_cnt(wrc_a)
    );

    cache_sram #(.SETS(SETS_B), .LAT(LAT_B)) u_dut_b (
        .CLK(clk), .RST(rst), .sramREN(ren_b), .sramWEN(wen_b),
        .sramaddr(addr_b), .sramstore(store_b), .cacheline(line_b),
        .sramstate(st_b), .rd_cnt(rdc_b), .wr_cnt(wrc_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [FRAME_W-1:0] mem_m [2][8];
    int n_rd_m [2];
    int n_wr_m [2];

    task automatic check_eq(input string tag, input logic [FRAME_W-1:0] act,
                            input logic [FRAME_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] f = '0;
        for (int i = 0; i < FRAME_W; i += 32) f = (f << 32) | FRAME_W'($urandom);
        return f;
    endfunction

    function automatic logic [FRAME_W-1:0] st_of(input bit b);
        return b ? FRAME_W'(st_b) : FRAME_W'(st_a);
    endfunction

    function automatic logic [FRAME_W-1:0] line_of(input bit b);
        return b ? line_b : line_a;
    endfunction

    task automatic set_in(input bit b, input logic r, input logic w,
                          input logic [2:0] a, input logic [FRAME_W-1:0] s);
        if (b) begin ren_b = r; wen_b = w; addr_b = a; store_b = s; end
        else   begin ren_a = r; wen_a = w; addr_a = a; store_a = s; end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) mem_m[b][i] = '0;
            n_rd_m[b] = 0;
            n_wr_m[b] = 0;
        end
    endtask

    // Called at a negedge with the selected DUT FREE; one full access.
    task automatic run_op(input bit b, input logic r, input logic w,
                          input logic [2:0] a, input logic [FRAME_W-1:0] s,
                          input bit drop, input string tag);
        logic [FRAME_W-1:0] exp;
        int lat  = b ? LAT_B : LAT_A;
        int sets = b ? SETS_B : SETS_A;
        if (w) begin
            exp = s;
            if (int'(a) < sets) mem_m[b][a] = s;
            n_wr_m[b]++;
        end else begin
            exp = (int'(a) < sets) ? mem_m[b][a] : '0;
            n_rd_m[b]++;
        end
        set_in(b, r, w, a, s);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1 && drop) set_in(b, 1'b0, 1'b0, ~a, rand_frame());
            if (k < lat) begin
                check_eq({tag, "_busy"}, st_of(b), FRAME_W'(BUSY));
            end else if (k == lat) begin
                check_eq({tag, "_access"}, st_of(b), FRAME_W'(ACCESS));
                check_eq({tag, "_line"}, line_of(b), exp);
                set_in(b, 1'b0, 1'b0, 3'd0, '0);
            end else begin
                check_eq({tag, "_free"}, st_of(b), FRAME_W'(FREE));
                check_eq({tag, "_hold"}, line_of(b), exp);
            end
        end
    endtask

    task automatic check_stats(input bit b, input string tag);
`ifdef CACHE_SRAM_STATS_EN
        check_eq({tag, "_rd_cnt"}, FRAME_W'(b ? rdc_b : rdc_a), FRAME_W'(n_rd_m[b]));
        check_eq({tag, "_wr_cnt"}, FRAME_W'(b ? wrc_b : wrc_a), FRAME_W'(n_wr_m[b]));
`else
        check_eq({tag, "_rd_cnt"}, FRAME_W'(b ? rdc_b : rdc_a), '0);
        check_eq({tag, "_wr_cnt"}, FRAME_W'(b ? wrc_b : wrc_a), '0);
`endif
    endtask

    initial begin
        logic [FRAME_W-1:0] f1, f2, f3, f7;
        logic r, w;
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 3'd0, '0);
        set_in(1, 1'b0, 1'b0, 3'd0, '0);
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_state", st_of(0), FRAME_W'(FREE));
        check_eq("rst_line", line_of(0), '0);
        check_stats(0, "rst");

        f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
        run_op(0, 1, 0, 3'd3, '0, 0, "rd_idx3");
        run_op(0, 0, 1, 3'd5, f1, 0, "wr_idx5");
        run_op(0, 1, 0, 3'd5, '0, 0, "rd_idx5");
        run_op(0, 1, 0, 3'd4, '0, 0, "rd_idx4");
        run_op(0, 1, 1, 3'd2, f2, 0, "both_idx2");
        run_op(0, 1, 0, 3'd2, '0, 0, "rd_idx2");
        f7 = mem_m[0][7];
        run_op(0, 0, 1, 3'd6, f3, 1, "wr_drop6");
        run_op(0, 1, 0, 3'd6, '0, 0, "rd_idx6");
        run_op(0, 1, 0, 3'd7, '0, 0, "rd_idx7");
        check_eq("idx7_unchanged", line_of(0), f7);

        for (int n = 0; n < 40; n++) begin
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            run_op(0, r, w, 3'($urandom_range(0, 7)), rand_frame(),
                   ($urandom_range(0, 3) == 0), "rand");
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_eq("idle_free", st_of(0), FRAME_W'(FREE));
            end
        end
        check_stats(0, "a_stats");

        // Second instance: LAT=3 timing and an out-of-range index (SETS=6).
        f1 = rand_frame();
        run_op(1, 0, 1, 3'd7, f1, 0, "b_wr_oor");
        run_op(1, 1, 0, 3'd7, '0, 0, "b_rd_oor");
        run_op(1, 0, 1, 3'd5, f1, 0, "b_wr5");
        run_op(1, 1, 0, 3'd5, '0, 0, "b_rd5");

        set_in(1, 1'b1, 1'b0, 3'd5, '0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            case (k % (LAT_B + 1))
                0:       check_eq("b_held_free", st_of(1), FRAME_W'(FREE));
                LAT_B:   check_eq("b_held_access", st_of(1), FRAME_W'(ACCESS));
                default: check_eq("b_held_busy", st_of(1), FRAME_W'(BUSY));
            endcase
            if (k == 11) set_in(1, 1'b0, 1'b0, 3'd0, '0);
        end
        n_rd_m[1] += 3;
        check_eq("b_held_line", line_of(1), f1);
        check_stats(1, "b_stats");

        // Reset while a write is in BUSY: write must not land.
        set_in(0, 1'b0, 1'b1, 3'd1, rand_frame());
        @(negedge clk);
        check_eq("rstbusy_busy", st_of(0), FRAME_W'(BUSY));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 1'b0, 1'b0, 3'd0, '0);
        model_clear();
        check_eq("rstbusy_free", st_of(0), FRAME_W'(FREE));
        check_eq("rstbusy_line", line_of(0), '0);
        run_op(0, 1, 0, 3'd1, '0, 0, "rd_idx1_after_rst");
        check_stats(0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
